// File: rtl/regfile_ctrl_pkg.sv
// Shared FSM state type and register-file constants for the writeback arbiter.
package regfile_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request/grant bus between the two requesters and the Register_File port.
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              RegWrite;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              busy;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  RegWrite, write_addr, write_data, busy
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output RegWrite, write_addr, write_data, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: ptr names the requester that wins a tie.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       next_ptr
);

    // Priority moves to whichever requester was not served; idle cycles keep it.
    always_comb begin
        grant    = 2'b00;
        next_ptr = ptr;
        if (valid[0] && (!valid[1] || !ptr)) begin
            grant    = 2'b01;
            next_ptr = 1'b1;
        end else if (valid[1]) begin
            grant    = 2'b10;
            next_ptr = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto the single Register_File write port.
// Define REGFILE_CLEAR_EN to sweep CLEAR_VALUE into x1..x31 after every reset.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int                ADDR_W      = 5,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input logic                    clk,
    input logic                    rst_n,
    regfile_write_arbiter_if.slave bus
);

    logic              inRun;
    logic [1:0]        reqValid;
    logic [1:0]        grant;
    logic              ptr_q;
    logic              ptr_d;
    logic              regWrite_q;
    logic [ADDR_W-1:0] writeAddr_q;
    logic [DATA_W-1:0] writeData_q;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

`ifdef REGFILE_CLEAR_EN
    state_e     state_q;
    logic [4:0] sweepCnt_q;

    assign inRun    = (state_q == RUN);
    assign bus.busy = (state_q == CLEAR);
`else
    assign inRun    = 1'b1;
    assign bus.busy = 1'b0;
`endif

    assign reqValid = {bus.req1_valid, bus.req0_valid} & {2{inRun}};

    rr_arbiter2 u_arb (
        .valid    (reqValid),
        .ptr      (ptr_q),
        .grant    (grant),
        .next_ptr (ptr_d)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign selAddr        = grant[1] ? bus.req1_addr : bus.req0_addr;
    assign selData        = grant[1] ? bus.req1_data : bus.req0_data;

    // The sweep counter wraps to zero after issuing x31; that cycle hands over to RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regWrite_q  <= 1'b0;
            writeAddr_q <= '0;
            writeData_q <= '0;
            ptr_q       <= 1'b0;
`ifdef REGFILE_CLEAR_EN
            state_q     <= CLEAR;
            sweepCnt_q  <= 5'd1;
        end else if (state_q == CLEAR) begin
            if (sweepCnt_q != 5'(REG_ZERO)) begin
                regWrite_q  <= 1'b1;
                writeAddr_q <= ADDR_W'(sweepCnt_q);
                writeData_q <= CLEAR_VALUE;
            end else begin
                regWrite_q  <= 1'b0;
                state_q     <= RUN;
            end
            sweepCnt_q <= sweepCnt_q + 5'd1;
`endif
        end else if (|grant) begin
            regWrite_q  <= (selAddr != ADDR_W'(REG_ZERO));
            writeAddr_q <= selAddr;
            writeData_q <= selData;
            ptr_q       <= ptr_d;
        end else begin
            regWrite_q  <= 1'b0;
        end
    end

    assign bus.RegWrite   = regWrite_q;
    assign bus.write_addr = writeAddr_q;
    assign bus.write_data = writeData_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the round-robin writeback rules.
module tb_regfile_write_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_write_arbiter #(
        .ADDR_W      (5),
        .DATA_W      (32),
        .CLEAR_VALUE (32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: pending request per requester, priority pointer, expected write port.
    int          ptr;
    bit          pend [2];
    logic [4:0]  pAddr [2];
    logic [31:0] pData [2];
    logic        expWe;
    logic [4:0]  expAddr;
    logic [31:0] expData;
    logic [31:0] modelRegs [32];
    bit          written [32];
    logic [31:0] dutRegs [32];

    // Register_File stand-in: commits on the edge that ends a RegWrite cycle.
    always @(posedge clk) begin
        if (bus.RegWrite === 1'b1) dutRegs[bus.write_addr] <= bus.write_data;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic post(input int r, input logic [4:0] a, input logic [31:0] d);
        pend[r]  = 1'b1;
        pAddr[r] = a;
        pData[r] = d;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        bus.req0_valid = pend[0];
        bus.req0_addr  = pAddr[0];
        bus.req0_data  = pData[0];
        bus.req1_valid = pend[1];
        bus.req1_addr  = pAddr[1];
        bus.req1_data  = pData[1];
    endtask

    task automatic runCycle(input string tag);
        int g;
        #1;
        if (pend[0] && pend[1]) g = ptr;
        else if (pend[0])       g = 0;
        else if (pend[1])       g = 1;
        else                    g = -1;
        checkOutput({tag, " ready0"}, bus.req0_ready, (g == 0));
        checkOutput({tag, " ready1"}, bus.req1_ready, (g == 1));
        @(posedge clk);
        if (g >= 0) begin
            expWe   = (pAddr[g] != 5'd0);
            expAddr = pAddr[g];
            expData = pData[g];
            ptr     = 1 - g;
            pend[g] = 1'b0;
            if (expWe) begin
                modelRegs[expAddr] = expData;
                written[expAddr]   = 1'b1;
            end
        end else begin
            expWe = 1'b0;
        end
        #1;
        checkOutput({tag, " RegWrite"}, bus.RegWrite, expWe);
        checkOutput({tag, " write_addr"}, bus.write_addr, expAddr);
        checkOutput({tag, " write_data"}, bus.write_data, expData);
        checkOutput({tag, " busy"}, bus.busy, 1'b0);
    endtask

`ifdef REGFILE_CLEAR_EN
    task automatic sweepCheck(input int stopAt);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int a = 1; a <= stopAt; a++) begin
            #1;
            checkOutput("sweep ready0", bus.req0_ready, 1'b0);
            checkOutput("sweep ready1", bus.req1_ready, 1'b0);
            @(posedge clk);
            #1;
            checkOutput("sweep RegWrite", bus.RegWrite, 1'b1);
            checkOutput("sweep write_addr", bus.write_addr, a);
            checkOutput("sweep write_data", bus.write_data, 32'h0);
            checkOutput("sweep busy", bus.busy, 1'b1);
            modelRegs[a] = 32'h0;
            written[a]   = 1'b1;
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (stopAt == 31) begin
            @(posedge clk);
            #1;
            checkOutput("sweep end RegWrite", bus.RegWrite, 1'b0);
            checkOutput("sweep end busy", bus.busy, 1'b0);
            expAddr = 5'd31;
            expData = 32'h0;
        end
    endtask
`endif

    task automatic resetDut(input string tag, input int sweepStop);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        ptr     = 0;
        expWe   = 1'b0;
        expAddr = '0;
        expData = '0;
        checkOutput({tag, " RegWrite"}, bus.RegWrite, 1'b0);
        checkOutput({tag, " write_addr"}, bus.write_addr, 5'd0);
        checkOutput({tag, " write_data"}, bus.write_data, 32'h0);
`ifdef REGFILE_CLEAR_EN
        checkOutput({tag, " busy"}, bus.busy, 1'b1);
`else
        checkOutput({tag, " busy"}, bus.busy, 1'b0);
`endif
        @(negedge clk);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;
`ifdef REGFILE_CLEAR_EN
        sweepCheck(sweepStop);
`else
        if (sweepStop < 0) $display("[TB] no clear sweep in this build");
`endif
    endtask

    initial begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        pAddr[0] = '0; pAddr[1] = '0;
        pData[0] = '0; pData[1] = '0;
        for (int r = 0; r < 32; r++) written[r] = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;

        resetDut("por", 12);
        resetDut("midsweep reset", 31);

        post(0, 5'd5, 32'hDEADBEEF);
        applyStimulus();
        runCycle("single");
        checkOutput("single const addr", bus.write_addr, 5'd5);
        checkOutput("single const data", bus.write_data, 32'hDEADBEEF);

        applyStimulus();
        runCycle("idle hold");

        post(1, 5'd0, 32'h1234);
        applyStimulus();
        runCycle("x0 write");
        checkOutput("x0 const RegWrite", bus.RegWrite, 1'b0);

        post(0, 5'd3, $urandom);
        post(1, 5'd4, $urandom);
        for (int i = 0; i < 4; i++) begin
            if (!pend[0]) post(0, 5'd3, $urandom);
            if (!pend[1]) post(1, 5'd4, $urandom);
            applyStimulus();
            runCycle("contention");
            checkOutput("contention order", bus.write_addr, (i % 2 == 0) ? 5'd3 : 5'd4);
            checkOutput("contention RegWrite", bus.RegWrite, 1'b1);
        end
        applyStimulus();
        runCycle("contention drain");

        post(0, 5'd7, 32'hA);
        post(1, 5'd7, 32'hB);
        applyStimulus();
        runCycle("collision first");
        applyStimulus();
        runCycle("collision second");
        applyStimulus();
        runCycle("collision idle");
        checkOutput("collision reg7", dutRegs[7], 32'hA);

        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 3) != 0)
                    post(r, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            end
            applyStimulus();
            runCycle("random");
        end
        while (pend[0] || pend[1]) begin
            applyStimulus();
            runCycle("random drain");
        end

        post(0, 5'd2, $urandom);
        applyStimulus();
        runCycle("pre-reset grant");
        post(0, 5'd9, $urandom);
        post(1, 5'd10, $urandom);
        applyStimulus();
        resetDut("midxfer reset", 31);

        post(0, 5'd11, $urandom);
        post(1, 5'd12, $urandom);
        applyStimulus();
        runCycle("post-reset ptr");
        checkOutput("post-reset ptr const addr", bus.write_addr, 5'd11);
        applyStimulus();
        runCycle("post-reset second");
        applyStimulus();
        runCycle("final idle");

        for (int r = 1; r < 32; r++) begin
            if (written[r]) checkOutput("regfile contents", dutRegs[r], modelRegs[r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
